// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - multi-phase actuated intersection controller
//
// Sequences NUM_PHASES mutually conflicting vehicle phases round-robin with
// vehicle-actuated green, demand-based phase skipping, all-red clearance,
// a latched pedestrian walk interval and a flashing-yellow maintenance mode.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   veh_det      per-phase vehicle detector (level)
//   ped_req      pedestrian request (level or pulse)
//   flash_mode   maintenance flash request (level)
//   green        per-phase green lamp
//   yellow       per-phase yellow lamp
//   red          per-phase red lamp
//   ped_green    pedestrian walk lamp
//   ped_pending  latched pedestrian request
//   phase_idx    current or last-served phase
module traffic_phase_ctrl #(
    parameter int NUM_PHASES   = 4,
    parameter int CNT_W        = 8,
    parameter int GREEN_MIN    = 5,
    parameter int GREEN_MAX    = 15,
    parameter int EXT_TIME     = 2,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int PED_TIME     = 4,
    parameter int FLASH_HALF   = 1,
    localparam int PHASE_W     = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_PHASES-1:0] veh_det,
    input  logic                  ped_req,
    input  logic                  flash_mode,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic                  ped_green,
    output logic                  ped_pending,
    output logic [PHASE_W-1:0]    phase_idx
);

    typedef enum logic [2:0] {
        ST_GREEN   = 3'd0,
        ST_YELLOW  = 3'd1,
        ST_ALL_RED = 3'd2,
        ST_PED     = 3'd3,
        ST_FLASH   = 3'd4
    } state_t;

    // Terminal timer values: an interval of N cycles ends when timer == N-1.
    localparam logic [CNT_W-1:0] GMIN_LAST  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] PED_LAST   = CNT_W'(PED_TIME - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] EXT_C      = CNT_W'(EXT_TIME);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASES - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [NUM_PHASES-1:0]   demand_q, demand_d;
    logic                    ped_pending_q, ped_pending_d;
    logic [CNT_W-1:0]        idle_q, idle_d;
    logic                    flash_on_q, flash_on_d;
    logic                    served_q, served_d;

    logic [CNT_W-1:0]        idle_now;
    logic [PHASE_W-1:0]      next_phase;
    logic [NUM_PHASES-1:0]   phase_onehot;
    int                      np_start;
    int                      np_idx;
    logic                    np_found;

    // Next phase to serve: first latched demand after phase_q, wrapping.
    // Until the first green after reset nothing has been served yet, so the
    // search starts at phase_q itself and phase 0 is served first.
    always_comb begin
        np_start   = served_q ? int'(phase_q) + 1 : int'(phase_q);
        np_idx     = 0;
        np_found   = 1'b0;
        next_phase = (np_start >= NUM_PHASES) ? PHASE_W'(np_start - NUM_PHASES)
                                              : PHASE_W'(np_start);
        for (int k = 0; k < NUM_PHASES; k++) begin
            np_idx = np_start + k;
            if (np_idx >= NUM_PHASES) begin
                np_idx = np_idx - NUM_PHASES;
            end
            if (!np_found && np_idx < NUM_PHASES && demand_q[np_idx]) begin
                np_found   = 1'b1;
                next_phase = PHASE_W'(np_idx);
            end
        end
    end

    // Consecutive detector-idle cycles of the green phase including this one,
    // saturating once the extension gap is reached.
    always_comb begin
        if (veh_det[phase_q]) begin
            idle_now = '0;
        end else if (idle_q >= EXT_C) begin
            idle_now = idle_q;
        end else begin
            idle_now = idle_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q + 1'b1;
        phase_d       = phase_q;
        demand_d      = demand_q;
        ped_pending_d = ped_pending_q;
        idle_d        = idle_q;
        flash_on_d    = 1'b1;
        served_d      = served_q;

        for (int i = 0; i < NUM_PHASES; i++) begin
            if (veh_det[i] && !(state_q == ST_GREEN && phase_q == PHASE_W'(i))) begin
                demand_d[i] = 1'b1;
            end
        end
        if (ped_req && state_q != ST_PED) begin
            ped_pending_d = 1'b1;
        end

        case (state_q)
            ST_GREEN: begin
                idle_d = idle_now;
                if (timer_q == GMAX_LAST ||
                    (timer_q >= GMIN_LAST && (idle_now >= EXT_C || flash_mode))) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (timer_q == YEL_LAST) begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_ALL_RED: begin
                if (timer_q == AR_LAST) begin
                    if (flash_mode) begin
                        state_d = ST_FLASH;
                    end else if (ped_pending_q) begin
                        // Entering the walk consumes the request, including
                        // one arriving on this same cycle.
                        state_d       = ST_PED;
                        ped_pending_d = 1'b0;
                    end else begin
                        state_d              = ST_GREEN;
                        phase_d              = next_phase;
                        demand_d[next_phase] = 1'b0;
                        idle_d               = '0;
                        served_d             = 1'b1;
                    end
                end
            end
            ST_PED: begin
                if (timer_q == PED_LAST) begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_FLASH: begin
                if (!flash_mode) begin
                    state_d  = ST_ALL_RED;
                    phase_d  = PHASE_LAST;
                    demand_d = '0;
                end else if (timer_q == FLASH_LAST) begin
                    // Timer only measures the current blink half here.
                    timer_d    = '0;
                    flash_on_d = ~flash_on_q;
                end else begin
                    flash_on_d = flash_on_q;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ALL_RED;
            timer_q       <= '0;
            phase_q       <= '0;
            demand_q      <= '0;
            ped_pending_q <= 1'b0;
            idle_q        <= '0;
            flash_on_q    <= 1'b1;
            served_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            phase_q       <= phase_d;
            demand_q      <= demand_d;
            ped_pending_q <= ped_pending_d;
            idle_q        <= idle_d;
            flash_on_q    <= flash_on_d;
            served_q      <= served_d;
        end
    end

    assign phase_onehot = NUM_PHASES'(1) << phase_q;

    always_comb begin
        green     = '0;
        yellow    = '0;
        red       = '1;
        ped_green = 1'b0;
        case (state_q)
            ST_GREEN: begin
                green = phase_onehot;
                red   = ~phase_onehot;
            end
            ST_YELLOW: begin
                yellow = phase_onehot;
                red    = ~phase_onehot;
            end
            ST_PED: begin
                ped_green = 1'b1;
            end
            ST_FLASH: begin
                red    = '0;
                yellow = flash_on_q ? '1 : '0;
            end
            default: begin
            end
        endcase
    end

    assign ped_pending = ped_pending_q;
    assign phase_idx   = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - randomized bench for traffic_phase_ctrl against an interval model
module tb_traffic_phase_ctrl;

    localparam int N    = 4;
    localparam int PW   = 2;
    localparam int GMIN = 5;
    localparam int GMAX = 15;
    localparam int EXT  = 2;
    localparam int YT   = 2;
    localparam int ART  = 1;
    localparam int PT   = 4;
    localparam int FH   = 1;

    localparam int M_GRN = 1;
    localparam int M_YEL = 2;
    localparam int M_AR  = 3;
    localparam int M_PED = 4;
    localparam int M_FL  = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  veh_det = '0;
    logic          ped_req = 1'b0;
    logic          flash_mode = 1'b0;
    logic [N-1:0]  green, yellow, red;
    logic          ped_green, ped_pending;
    logic [PW-1:0] phase_idx;

    int checks = 0;
    int errors = 0;

    // Reference model: the current interval, how long it has lasted, the
    // phase being (or last) served and the outstanding requests.
    int           m_st;
    int           m_t;
    int           m_ph;
    bit [N-1:0]   m_dem;
    bit           m_ped;
    int           m_idle;
    bit           m_first;
    bit           fm_hold;

    traffic_phase_ctrl #(
        .NUM_PHASES(N), .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .EXT_TIME(EXT), .YELLOW_TIME(YT), .ALL_RED_TIME(ART),
        .PED_TIME(PT), .FLASH_HALF(FH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .veh_det(veh_det), .ped_req(ped_req),
        .flash_mode(flash_mode), .green(green), .yellow(yellow), .red(red),
        .ped_green(ped_green), .ped_pending(ped_pending), .phase_idx(phase_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = M_AR;
        m_t     = 0;
        m_ph    = 0;
        m_dem   = '0;
        m_ped   = 1'b0;
        m_idle  = 0;
        m_first = 1'b1;
    endtask

    function automatic int pick_phase();
        int base = m_first ? m_ph : m_ph + 1;
        for (int k = 0; k < N; k++) begin
            if (m_dem[(base + k) % N]) return (base + k) % N;
        end
        return base % N;
    endfunction

    task automatic model_step(input logic [N-1:0] vd, input bit pr, input bit fm);
        int         ns     = m_st;
        int         nph    = m_ph;
        bit [N-1:0] nd     = m_dem;
        bit         npd    = m_ped;
        int         nidle  = m_idle;
        bit         nfirst = m_first;
        int         lasted = m_t + 1;
        for (int i = 0; i < N; i++) begin
            if (vd[i] && !(m_st == M_GRN && m_ph == i)) nd[i] = 1'b1;
        end
        if (pr && m_st != M_PED) npd = 1'b1;
        case (m_st)
            M_GRN: begin
                nidle = vd[m_ph] ? 0 : m_idle + 1;
                if (lasted >= GMAX || (lasted >= GMIN && (nidle >= EXT || fm))) ns = M_YEL;
            end
            M_YEL: if (lasted == YT) ns = M_AR;
            M_AR: begin
                if (lasted == ART) begin
                    if (fm) ns = M_FL;
                    else if (m_ped) begin
                        ns  = M_PED;
                        npd = 1'b0;
                    end else begin
                        ns      = M_GRN;
                        nph     = pick_phase();
                        nd[nph] = 1'b0;
                        nidle   = 0;
                        nfirst  = 1'b0;
                    end
                end
            end
            M_PED: if (lasted == PT) ns = M_AR;
            M_FL: begin
                if (!fm) begin
                    ns  = M_AR;
                    nph = N - 1;
                    nd  = '0;
                end
            end
            default: ns = M_AR;
        endcase
        m_t     = (ns != m_st) ? 0 : lasted;
        m_st    = ns;
        m_ph    = nph;
        m_dem   = nd;
        m_ped   = npd;
        m_idle  = nidle;
        m_first = nfirst;
    endtask

    task automatic compare_all();
        logic [N-1:0] eg = '0;
        logic [N-1:0] ey = '0;
        logic [N-1:0] er = '1;
        logic         ep = 1'b0;
        case (m_st)
            M_GRN: begin eg[m_ph] = 1'b1; er = ~eg; end
            M_YEL: begin ey[m_ph] = 1'b1; er = ~ey; end
            M_PED: ep = 1'b1;
            M_FL: begin er = '0; ey = (((m_t / FH) % 2) == 0) ? '1 : '0; end
            default: ;
        endcase
        check("green", 32'(green), 32'(eg));
        check("yellow", 32'(yellow), 32'(ey));
        check("red", 32'(red), 32'(er));
        check("ped_green", 32'(ped_green), 32'(ep));
        check("ped_pending", 32'(ped_pending), 32'(m_ped));
        check("phase_idx", 32'(phase_idx), 32'(m_ph));
    endtask

    // Called at a falling edge: compare, drive the next inputs, advance the
    // model over the coming rising edge, then wait for the next falling edge.
    task automatic cycle(input logic [N-1:0] vd, input bit pr, input bit fm);
        compare_all();
        veh_det    = vd;
        ped_req    = pr;
        flash_mode = fm;
        model_step(vd, pr, fm);
        @(negedge clk);
    endtask

    task automatic rand_cycle(input bit allow_flash);
        logic [N-1:0] vd;
        for (int i = 0; i < N; i++) vd[i] = ($urandom % 3 == 0);
        if (allow_flash && ($urandom % 50 == 0)) fm_hold = ~fm_hold;
        if (!allow_flash) fm_hold = 1'b0;
        cycle(vd, ($urandom % 30 == 0), fm_hold);
    endtask

    initial begin
        bit hit;
        fm_hold = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_red", 32'(red), 32'({N{1'b1}}));
        check("rst_green", 32'(green), 32'h0);
        check("rst_yellow", 32'(yellow), 32'h0);
        check("rst_ped_green", 32'(ped_green), 32'h0);
        reset_n = 1'b1;

        // Idle run: phase 0 first, then min-green round robin.
        repeat (40) cycle('0, 1'b0, 1'b0);
        // Sparse random demand and pedestrian requests.
        for (int c = 0; c < 260; c++) begin
            logic [N-1:0] vd;
            for (int i = 0; i < N; i++) vd[i] = ($urandom % 4 == 0);
            cycle(vd, ($urandom % 25 == 0), 1'b0);
        end
        // Saturated demand drives every green to its maximum.
        repeat (150) cycle('1, 1'b0, 1'b0);
        // Mixed traffic with maintenance flash toggling.
        repeat (1700) rand_cycle(1'b1);
        // Leave flash and let the controller settle back into service.
        fm_hold = 1'b0;
        repeat (30) rand_cycle(1'b0);

        // Asynchronous reset in the middle of a yellow interval.
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (m_st == M_YEL) hit = 1'b1;
            else rand_cycle(1'b0);
        end
        check("yellow_reached", 32'(hit), 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_red", 32'(red), 32'({N{1'b1}}));
        check("async_green", 32'(green), 32'h0);
        check("async_yellow", 32'(yellow), 32'h0);
        check("async_ped_green", 32'(ped_green), 32'h0);
        check("async_ped_pending", 32'(ped_pending), 32'h0);
        check("async_phase", 32'(phase_idx), 32'h0);
        veh_det    = '0;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (600) rand_cycle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
